inst_align_queue: RTL and testbench

//  Next-generation decode front end: sits between fetch and the dec32/dec16/regfile decode stage.

---
 rtl/dec_pkg.sv | 19 +
 rtl/iq_fifo.sv | 73 +++++++
 rtl/inst_align_queue.sv | 130 +++++++++++++
 tb/tb_inst_align_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types for the instruction align queue: queue entry layout and RVC halfword helpers.
package dec_pkg;

    localparam int IQ_XLEN = 64;
    localparam logic [1:0] HW_RVC_MASK = 2'b11;

    typedef struct packed {
        logic [IQ_XLEN-1:0] pc;
        logic [31:0]        inst;
        logic               compressed;
        logic               illegal;
    } iq_ent_t;

    // A halfword starts a 16-bit instruction unless its two low bits are both set.
    function automatic logic isCompressed(input logic [15:0] hw);
        return (hw[1:0] & HW_RVC_MASK) != HW_RVC_MASK;
    endfunction

endpackage

// File: rtl/iq_fifo.sv
// Ring buffer of decoded-ready entries: up to two pushes and one pop per cycle, plus flush.
module iq_fifo
    import dec_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic [1:0]    pushCnt_i,
    input  iq_ent_t       push0_i,
    input  iq_ent_t       push1_i,
    input  logic          pop_i,
    output iq_ent_t       head_o,
    output logic          headValid_o,
    output logic [AW:0]   count_o
);

    iq_ent_t       mem_q [DEPTH];
    iq_ent_t       last_q;
    logic [AW:0]   wrPtr_q, wrPtr_d;
    logic [AW:0]   rdPtr_q, rdPtr_d;
    logic [AW:0]   wrPtrNext;
    logic          doPop;

    assign count_o     = wrPtr_q - rdPtr_q;
    assign headValid_o = (count_o != '0);
    assign doPop       = pop_i && headValid_o && !flush_i;
    assign wrPtrNext   = wrPtr_q + 1'b1;

    // Once drained, the outputs keep showing the entry that was consumed last.
    assign head_o = headValid_o ? mem_q[rdPtr_q[AW-1:0]] : last_q;

    always_comb begin
        wrPtr_d = wrPtr_q + {{(AW-1){1'b0}}, pushCnt_i};
        rdPtr_d = rdPtr_q + {{AW{1'b0}}, doPop};
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            last_q  <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            if (doPop) begin
                last_q <= mem_q[rdPtr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush_i) begin
            if (pushCnt_i != 2'd0) begin
                mem_q[wrPtr_q[AW-1:0]] <= push0_i;
            end
            if (pushCnt_i == 2'd2) begin
                mem_q[wrPtrNext[AW-1:0]] <= push1_i;
            end
        end
    end

endmodule

// File: rtl/inst_align_queue.sv
// Fetch-to-decode realignment queue for 16/32-bit RISC-V instructions.
// Define RVC_EN to build compressed support (halfword parse and split-instruction hold register).
module inst_align_queue
    import dec_pkg::*;
#(
    parameter int XLEN  = IQ_XLEN,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            bj_en,
    input  logic            trap_en,
    input  logic            f_valid,
    output logic            f_ready,
    input  logic [XLEN-1:0] f_pc,
    input  logic [31:0]     f_data,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [XLEN-1:0] d_pc,
    output logic [31:0]     d_inst,
    output logic            d_compressed,
    output logic            d_illegal,
    output logic [CW-1:0]   count
);

    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic     flush;
    logic     accept;
    logic [1:0] pushCnt;
    iq_ent_t  push0, push1, head;

    assign flush   = clear | bj_en | trap_en;
    // Needs room for two entries so a word that yields two instructions never overflows.
    assign f_ready = rst_n && (count <= READY_MAX);
    assign accept  = f_valid && f_ready && !flush;

`ifdef RVC_EN
    logic            holdValid_q, holdValid_d;
    logic [15:0]     holdHw_q, holdHw_d;
    logic [XLEN-1:0] holdPc_q, holdPc_d;
    logic            leadTaken, leadIs32;
    iq_ent_t         leadEnt, hw1Ent;

    always_comb begin
        leadTaken = holdValid_q || !f_pc[1];
        leadIs32  = !holdValid_q && !f_pc[1] && !isCompressed(f_data[15:0]);

        hw1Ent            = '0;
        hw1Ent.pc         = f_pc | XLEN'(2);
        hw1Ent.inst       = {16'h0, f_data[31:16]};
        hw1Ent.compressed = 1'b1;

        leadEnt = '0;
        if (holdValid_q) begin
            leadEnt.pc   = holdPc_q;
            leadEnt.inst = {f_data[15:0], holdHw_q};
        end else if (isCompressed(f_data[15:0])) begin
            leadEnt.pc         = f_pc;
            leadEnt.inst       = {16'h0, f_data[15:0]};
            leadEnt.compressed = 1'b1;
        end else begin
            leadEnt.pc   = f_pc;
            leadEnt.inst = f_data;
        end

        push0   = leadTaken ? leadEnt : hw1Ent;
        push1   = hw1Ent;
        pushCnt = 2'd0;
        if (accept) begin
            pushCnt = {1'b0, leadTaken} + {1'b0, !leadIs32 && isCompressed(f_data[31:16])};
        end

        holdValid_d = holdValid_q;
        holdHw_d    = holdHw_q;
        holdPc_d    = holdPc_q;
        if (flush) begin
            holdValid_d = 1'b0;
        end else if (accept) begin
            holdValid_d = !leadIs32 && !isCompressed(f_data[31:16]);
            holdHw_d    = f_data[31:16];
            holdPc_d    = f_pc | XLEN'(2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdValid_q <= 1'b0;
            holdHw_q    <= '0;
            holdPc_q    <= '0;
        end else begin
            holdValid_q <= holdValid_d;
            holdHw_q    <= holdHw_d;
            holdPc_q    <= holdPc_d;
        end
    end
`else
    always_comb begin
        push0         = '0;
        push0.pc      = f_pc;
        push0.inst    = f_data;
        push0.illegal = f_pc[1] || (f_data[1:0] != HW_RVC_MASK);
        push1         = '0;
        pushCnt       = accept ? 2'd1 : 2'd0;
    end
`endif

    iq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .pushCnt_i  (pushCnt),
        .push0_i    (push0),
        .push1_i    (push1),
        .pop_i      (d_ready),
        .head_o     (head),
        .headValid_o(d_valid),
        .count_o    (count)
    );

    assign d_pc         = head.pc;
    assign d_inst       = head.inst;
    assign d_compressed = head.compressed;
    assign d_illegal    = head.illegal;

endmodule

// File: tb/tb_inst_align_queue.sv
// Randomized self-checking bench for inst_align_queue against a halfword-stream queue model.
// Honours RVC_EN the same way the design does.
module tb_inst_align_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst_n;
    logic            clear, bj_en, trap_en;
    logic            f_valid, f_ready;
    logic [XLEN-1:0] f_pc;
    logic [31:0]     f_data;
    logic            d_valid, d_ready;
    logic [XLEN-1:0] d_pc;
    logic [31:0]     d_inst;
    logic            d_compressed, d_illegal;
    logic [CW-1:0]   count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        c;
        logic        ill;
    } entT;

    entT         modelQ[$];
    bit          holdV;
    logic [15:0] holdHw;
    logic [63:0] holdPc;

    inst_align_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bj_en(bj_en), .trap_en(trap_en),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_data(f_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_inst(d_inst),
        .d_compressed(d_compressed), .d_illegal(d_illegal), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic entT mkEnt(logic [63:0] pc, logic [31:0] inst, logic c, logic ill);
        entT e;
        e.pc = pc; e.inst = inst; e.c = c; e.ill = ill;
        return e;
    endfunction

    // Compare every visible output with the model's current queue contents.
    task automatic modelCompare();
        int sz;
        sz = modelQ.size();
        checkOutput("count", 64'(count), 64'(sz));
        checkOutput("d_valid", 64'(d_valid), 64'(sz != 0));
        checkOutput("f_ready", 64'(f_ready), 64'((DEPTH - sz) >= 2));
        if (sz != 0) begin
            checkOutput("d_pc", d_pc, modelQ[0].pc);
            checkOutput("d_inst", 64'(d_inst), 64'(modelQ[0].inst));
            checkOutput("d_compressed", 64'(d_compressed), 64'(modelQ[0].c));
            checkOutput("d_illegal", 64'(d_illegal), 64'(modelQ[0].ill));
        end
    endtask

    // One clock edge of the reference behaviour, using the state seen before the edge.
    task automatic modelStep(input bit fv, input logic [63:0] pc, input logic [31:0] data,
                             input bit dr, input bit fl);
        int   sz;
        bit   rdy;
        entT  dummy;
        logic [15:0] hs[$];
        logic [63:0] ps[$];
        int   i;
        sz  = modelQ.size();
        rdy = (DEPTH - sz) >= 2;
        if (fl) begin
            modelQ.delete();
            holdV = 1'b0;
            return;
        end
        if (dr && sz > 0) dummy = modelQ.pop_front();
        if (fv && rdy) begin
`ifdef RVC_EN
            if (holdV) begin
                hs.push_back(holdHw);
                ps.push_back(holdPc);
                holdV = 1'b0;
                hs.push_back(data[15:0]);
                ps.push_back(pc);
            end else if (!pc[1]) begin
                hs.push_back(data[15:0]);
                ps.push_back(pc);
            end
            hs.push_back(data[31:16]);
            ps.push_back(pc | 64'h2);
            i = 0;
            while (i < hs.size()) begin
                if (hs[i][1:0] != 2'b11) begin
                    modelQ.push_back(mkEnt(ps[i], {16'h0, hs[i]}, 1'b1, 1'b0));
                    i += 1;
                end else if (i + 1 < hs.size()) begin
                    modelQ.push_back(mkEnt(ps[i], {hs[i+1], hs[i]}, 1'b0, 1'b0));
                    i += 2;
                end else begin
                    holdV  = 1'b1;
                    holdHw = hs[i];
                    holdPc = ps[i];
                    i += 1;
                end
            end
`else
            modelQ.push_back(mkEnt(pc, data, 1'b0, pc[1] || (data[1:0] != 2'b11)));
`endif
        end
    endtask

    // Entered at a falling edge; drives one cycle of inputs and checks the result a cycle later.
    task automatic applyStimulus(input bit fv, input logic [63:0] pc, input logic [31:0] data,
                                 input bit dr, input int flushKind);
        f_valid = fv;
        f_pc    = pc;
        f_data  = data;
        d_ready = dr;
        clear   = (flushKind == 1);
        bj_en   = (flushKind == 2);
        trap_en = (flushKind == 3);
        @(posedge clk);
        modelStep(fv, pc, data, dr, flushKind != 0);
        @(negedge clk);
        modelCompare();
    endtask

    function automatic logic [15:0] randHw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    initial begin
        logic [63:0] pc;
        bit          slowDrain;
        int          fk;

        rst_n = 1'b0; clear = 1'b0; bj_en = 1'b0; trap_en = 1'b0;
        f_valid = 1'b0; f_pc = '0; f_data = '0; d_ready = 1'b0;
        holdV = 1'b0; holdHw = '0; holdPc = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_d_valid", 64'(d_valid), 64'd0);
        checkOutput("rst_d_pc", d_pc, 64'd0);
        checkOutput("rst_d_inst", 64'(d_inst), 64'd0);
        checkOutput("rst_d_compressed", 64'(d_compressed), 64'd0);
        checkOutput("rst_d_illegal", 64'(d_illegal), 64'd0);
        checkOutput("rst_f_ready", 64'(f_ready), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        modelCompare();

        applyStimulus(1, 64'h1000, 32'h00500093, 0, 0);
        checkOutput("t1_count", 64'(count), 64'd1);
        checkOutput("t1_pc", d_pc, 64'h1000);
        checkOutput("t1_inst", 64'(d_inst), 64'h00500093);
        checkOutput("t1_compressed", 64'(d_compressed), 64'd0);
        applyStimulus(0, 0, 0, 0, 1);

`ifdef RVC_EN
        applyStimulus(1, 64'h2000, 32'h00050001, 0, 0);
        checkOutput("t2_count", 64'(count), 64'd2);
        checkOutput("t2_pc0", d_pc, 64'h2000);
        checkOutput("t2_inst0", 64'(d_inst), 64'h0001);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t2_pc1", d_pc, 64'h2002);
        checkOutput("t2_inst1", 64'(d_inst), 64'h0005);
        checkOutput("t2_c1", 64'(d_compressed), 64'd1);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(1, 64'h3000, 32'h00930505, 0, 0);
        checkOutput("t3_count_a", 64'(count), 64'd1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 64'h3004, 32'h00020050, 0, 0);
        checkOutput("t3_count_b", 64'(count), 64'd2);
        checkOutput("t3_split_pc", d_pc, 64'h3002);
        checkOutput("t3_split_inst", 64'(d_inst), 64'h00500093);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3_rvc_pc", d_pc, 64'h3006);
        applyStimulus(0, 0, 0, 0, 1);
`else
        applyStimulus(1, 64'h4002, 32'h00500093, 0, 0);
        checkOutput("t6_misaligned", 64'(d_illegal), 64'd1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 64'h4000, 32'h00000001, 0, 0);
        checkOutput("t6_rvc_illegal", 64'(d_illegal), 64'd1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 64'h4000, 32'h00500093, 0, 0);
        checkOutput("t6_legal", 64'(d_illegal), 64'd0);
        applyStimulus(0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 64'h5000 + 64'(4 * i), 32'h00500093, 0, 0);
        end
        checkOutput("t4_full_count", 64'(count), 64'd7);
        checkOutput("t4_full_ready", 64'(f_ready), 64'd0);
        applyStimulus(1, 64'h5100, 32'h00500093, 1, 0);
        checkOutput("t4_drain_count", 64'(count), 64'd6);
        checkOutput("t4_drain_ready", 64'(f_ready), 64'd1);
        checkOutput("t4_next_pc", d_pc, 64'h5004);

        applyStimulus(1, 64'h6000, 32'h00930505, 0, 0);
        applyStimulus(1, 64'h6004, 32'h00500093, 0, 2);
        checkOutput("t5_count", 64'(count), 64'd0);
        checkOutput("t5_d_valid", 64'(d_valid), 64'd0);
        applyStimulus(1, 64'h7000, 32'h00500093, 0, 0);
        checkOutput("t5_after_inst", 64'(d_inst), 64'h00500093);
        checkOutput("t5_after_pc", d_pc, 64'h7000);

        applyStimulus(1, 64'h7004, 32'h00930505, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_count", 64'(count), 64'd0);
        checkOutput("arst_d_valid", 64'(d_valid), 64'd0);
        checkOutput("arst_f_ready", 64'(f_ready), 64'd0);
        modelQ.delete();
        holdV = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        slowDrain = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0) slowDrain = ($urandom_range(1, 0) == 1);
            pc = {32'($urandom), 32'($urandom)} & ~64'h3;
`ifdef RVC_EN
            if (!holdV && $urandom_range(3, 0) == 0) pc[1] = 1'b1;
`else
            if ($urandom_range(7, 0) == 0) pc[1] = 1'b1;
`endif
            fk = ($urandom_range(39, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            applyStimulus($urandom_range(3, 0) != 0, pc, {randHw(), randHw()},
                          slowDrain ? ($urandom_range(3, 0) == 0) : ($urandom_range(2, 0) != 0),
                          fk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
